// File: rtl/voice_allocator_pkg.sv
// Shared types and sizing for the voice allocator: widths, FSM states,
// per-voice slot record and the slot-table update command.
package synth_pkg;

  localparam int NUM_VOICES = 4;
  localparam int VOICE_W    = 2;
  localparam int NOTE_W     = 7;
  localparam int D_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ISSUE
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RETRIG,
    CMD_ALLOC,
    CMD_STEAL,
    CMD_RELEASE
  } slot_cmd_e;

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
    logic [VOICE_W-1:0] age;
  } voice_slot_t;

  // Number of sounding voices, one bit wider than a voice index so a full
  // table can be represented.
  function automatic logic [VOICE_W:0] count_active(input logic [NUM_VOICES-1:0] act);
    logic [VOICE_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      n = n + {{VOICE_W{1'b0}}, act[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/voice_allocator_voice_slot_table.sv
// Per-voice registers (active flag, note, age) with a scan read port and a
// single ISSUE-cycle update command that keeps the ages of the sounding
// voices a permutation of 0..k-1 (0 = newest).
module voice_slot_table
(
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [synth_pkg::VOICE_W-1:0] rd_idx,
  output synth_pkg::voice_slot_t       rd_slot,
  input  synth_pkg::slot_cmd_e         cmd,
  input  logic [synth_pkg::VOICE_W-1:0] cmd_idx,
  input  logic [synth_pkg::NOTE_W-1:0]  cmd_note,
  output logic [synth_pkg::NUM_VOICES-1:0] active
);
  import synth_pkg::*;

  localparam logic [VOICE_W-1:0] AGE_MAX = VOICE_W'(NUM_VOICES - 1);
  localparam logic [VOICE_W-1:0] AGE_ONE = VOICE_W'(1);

  voice_slot_t        slots [NUM_VOICES];
  logic [VOICE_W-1:0] ref_age;

  assign rd_slot = slots[rd_idx];
  assign ref_age = slots[cmd_idx].age;

  // Apply the allocation decision to every slot's ownership and age
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        slots[i].active <= 1'b0;
        slots[i].note   <= '0;
        slots[i].age    <= AGE_MAX;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        case (cmd)
          CMD_RETRIG: begin
            if (VOICE_W'(i) == cmd_idx) begin
              slots[i].note <= cmd_note;
              slots[i].age  <= '0;
            end else if (slots[i].active && (slots[i].age < ref_age)) begin
              slots[i].age <= slots[i].age + AGE_ONE;
            end
          end
          CMD_ALLOC: begin
            if (VOICE_W'(i) == cmd_idx) begin
              slots[i].active <= 1'b1;
              slots[i].note   <= cmd_note;
              slots[i].age    <= '0;
            end else if (slots[i].active) begin
              slots[i].age <= slots[i].age + AGE_ONE;
            end
          end
          CMD_STEAL: begin
            if (VOICE_W'(i) == cmd_idx) begin
              slots[i].note <= cmd_note;
              slots[i].age  <= '0;
            end else begin
              slots[i].age <= slots[i].age + AGE_ONE;
            end
          end
          CMD_RELEASE: begin
            if (VOICE_W'(i) == cmd_idx) begin
              slots[i].active <= 1'b0;
              slots[i].age    <= AGE_MAX;
            end else if (slots[i].active && (slots[i].age > ref_age)) begin
              slots[i].age <= slots[i].age - AGE_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Gather the per-voice sounding flags into one vector
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active[i] = slots[i].active;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: accepts one note event, scans the voice table
// one slot per cycle, then retriggers / allocates / steals / releases a voice
// and strobes the new channel divider to the NCO bank.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2,
  parameter int NOTE_W     = 7,
  parameter int D_W        = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  note_valid,
  input  logic                  note_on,
  input  logic [NOTE_W-1:0]     note_num,
  input  logic [D_W-1:0]        note_div,
  output logic                  note_ready,
  output logic [VOICE_W-1:0]    midi_chan_selected,
  output logic [D_W-1:0]        midi_chan_divider,
  output logic                  midi_chan_update,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  steal_event
);
  import synth_pkg::*;

  localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);
  localparam logic [VOICE_W-1:0] IDX_ONE  = VOICE_W'(1);
  localparam logic [VOICE_W:0]   CNT_ONE  = (VOICE_W + 1)'(1);

  state_e              state;
  state_e              state_next;
  logic                accept;
  logic [VOICE_W-1:0]  scan_idx;

  logic                on_q;
  logic [NOTE_W-1:0]   num_q;
  logic [D_W-1:0]      div_q;

  logic                match_found;
  logic [VOICE_W-1:0]  match_idx;
  logic                free_found;
  logic [VOICE_W-1:0]  free_idx;
  logic [VOICE_W-1:0]  oldest_idx;

  logic [VOICE_W-1:0]  sel_q;
  logic [D_W-1:0]      div_hold_q;

  voice_slot_t         rd_slot;
  logic [NUM_VOICES-1:0] active;
  logic [VOICE_W:0]    active_cnt;
  logic [VOICE_W:0]    oldest_age;

  slot_cmd_e           cmd;
  logic [VOICE_W-1:0]  cmd_idx;
  logic                strobe;
  logic [D_W-1:0]      strobe_div;
  logic                steal;

  assign accept     = note_valid & note_ready;
  assign active_cnt = count_active(active);
  assign oldest_age = active_cnt - CNT_ONE;

  voice_slot_table u_slots (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .rd_idx   (scan_idx),
    .rd_slot  (rd_slot),
    .cmd      (cmd),
    .cmd_idx  (cmd_idx),
    .cmd_note (num_q),
    .active   (active)
  );

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: one scan cycle per voice, then a single issue cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SEARCH;
      SEARCH:  if (scan_idx == LAST_IDX) state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the accepted event and step the scan index through the table
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      on_q     <= 1'b0;
      num_q    <= '0;
      div_q    <= '0;
      scan_idx <= '0;
    end else if (accept) begin
      on_q     <= note_on;
      num_q    <= note_num;
      div_q    <= note_div;
      scan_idx <= '0;
    end else if (state == SEARCH) begin
      scan_idx <= scan_idx + IDX_ONE;
    end
  end

  // Track matching note, lowest free slot and oldest sounding voice during the scan
  always_ff @(posedge sys_clk) begin
    if (rst || accept) begin
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
    end else if (state == SEARCH) begin
      if (rd_slot.active && (rd_slot.note == num_q) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!rd_slot.active && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
      if (rd_slot.active && ({1'b0, rd_slot.age} == oldest_age)) begin
        oldest_idx <= scan_idx;
      end
    end
  end

  // FSM outputs: ready in IDLE, and the allocation decision in ISSUE
  always_comb begin
    note_ready = (state == IDLE) && !rst;
    cmd        = CMD_NONE;
    cmd_idx    = '0;
    strobe     = 1'b0;
    strobe_div = '0;
    steal      = 1'b0;
    if ((state == ISSUE) && !rst) begin
      if (on_q) begin
        strobe     = 1'b1;
        strobe_div = div_q;
        if (match_found) begin
          cmd     = CMD_RETRIG;
          cmd_idx = match_idx;
        end else if (free_found) begin
          cmd     = CMD_ALLOC;
          cmd_idx = free_idx;
        end else begin
          cmd     = CMD_STEAL;
          cmd_idx = oldest_idx;
          steal   = 1'b1;
        end
      end else if (match_found) begin
        cmd     = CMD_RELEASE;
        cmd_idx = match_idx;
        strobe  = 1'b1;
      end
    end
  end

  // Remember the last programmed channel so the bank interface holds between strobes
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sel_q      <= '0;
      div_hold_q <= '0;
    end else if (strobe) begin
      sel_q      <= cmd_idx;
      div_hold_q <= strobe_div;
    end
  end

  assign midi_chan_update   = strobe;
  assign steal_event        = steal;
  assign midi_chan_selected = strobe ? cmd_idx : sel_q;
  assign midi_chan_divider  = strobe ? strobe_div : div_hold_q;
  assign voice_active       = active;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator. The reference model keeps the
// sounding voices in a recency-ordered queue (front = newest) and derives
// every expected strobe, voice, divider and steal from that ordering.
module tb_voice_allocator;

  localparam int NV = 4;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        note_valid = 1'b0;
  logic        note_on = 1'b0;
  logic [6:0]  note_num = '0;
  logic [15:0] note_div = '0;
  logic        note_ready;
  logic [1:0]  midi_chan_selected;
  logic [15:0] midi_chan_divider;
  logic        midi_chan_update;
  logic [3:0]  voice_active;
  logic        steal_event;

  int errors = 0;
  int checks = 0;

  int          order[$];
  logic [6:0]  mnote [NV];
  logic [1:0]  last_sel;
  logic [15:0] last_div;

  always #5 sys_clk = ~sys_clk;

  voice_allocator dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .note_valid         (note_valid),
    .note_on            (note_on),
    .note_num           (note_num),
    .note_div           (note_div),
    .note_ready         (note_ready),
    .midi_chan_selected (midi_chan_selected),
    .midi_chan_divider  (midi_chan_divider),
    .midi_chan_update   (midi_chan_update),
    .voice_active       (voice_active),
    .steal_event        (steal_event)
  );

  function automatic void model_reset();
    order.delete();
    for (int i = 0; i < NV; i++) mnote[i] = '0;
    last_sel = '0;
    last_div = '0;
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] a;
    a = '0;
    for (int i = 0; i < order.size(); i++) a[order[i]] = 1'b1;
    return a;
  endfunction

  function automatic void model_apply(input bit on, input logic [6:0] num, input logic [15:0] div,
                                      output bit exp_strobe, output int exp_sel, output bit exp_steal);
    int pos;
    int v;
    logic [3:0] act;
    pos = -1;
    for (int i = 0; i < order.size(); i++) if (mnote[order[i]] == num) pos = i;
    exp_strobe = 1'b0;
    exp_sel    = 0;
    exp_steal  = 1'b0;
    if (on) begin
      if (pos >= 0) begin
        v = order[pos];
        order.delete(pos);
      end else if (order.size() < NV) begin
        act = model_active();
        v = 0;
        while (act[v]) v++;
      end else begin
        v = order[order.size() - 1];
        void'(order.pop_back());
        exp_steal = 1'b1;
      end
      order.push_front(v);
      mnote[v]   = num;
      exp_strobe = 1'b1;
      exp_sel    = v;
      last_sel   = 2'(v);
      last_div   = div;
    end else if (pos >= 0) begin
      v = order[pos];
      order.delete(pos);
      exp_strobe = 1'b1;
      exp_sel    = v;
      last_sel   = 2'(v);
      last_div   = '0;
    end
  endfunction

  task automatic check_event(input string tag, input bit on, input logic [6:0] num, input logic [15:0] div);
    bit          exp_strobe;
    bit          exp_steal;
    int          exp_sel;
    logic [3:0]  exp_act;
    int          n_strobe, off, n_steal, n_low, waitc;
    logic [1:0]  got_sel;
    logic [15:0] got_div;
    model_apply(on, num, div, exp_strobe, exp_sel, exp_steal);
    exp_act = model_active();
    waitc = 0;
    @(negedge sys_clk);
    while (note_ready !== 1'b1 && waitc < 20) begin
      @(negedge sys_clk);
      waitc++;
    end
    checks++;
    if (note_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_wait got=%b exp=1", tag, note_ready);
    end
    note_valid = 1'b1;
    note_on    = on;
    note_num   = num;
    note_div   = div;
    @(posedge sys_clk);
    #1 note_valid = 1'b0;
    n_strobe = 0; off = 0; n_steal = 0; n_low = 0; got_sel = '0; got_div = '0;
    for (int k = 1; k <= NV + 4; k++) begin
      @(negedge sys_clk);
      if (note_ready !== 1'b1) n_low++;
      if (steal_event === 1'b1) n_steal++;
      if (midi_chan_update === 1'b1) begin
        n_strobe++;
        off     = k;
        got_sel = midi_chan_selected;
        got_div = midi_chan_divider;
      end
    end
    checks++;
    if (n_strobe != (exp_strobe ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s strobe_count got=%0d exp=%0d", tag, n_strobe, exp_strobe ? 1 : 0);
    end
    if (exp_strobe) begin
      checks++;
      if (off != NV + 1) begin
        errors++;
        $display("[TB] FAIL %s strobe_cycle got=A+%0d exp=A+%0d", tag, off, NV + 1);
      end
      checks++;
      if (got_sel !== 2'(exp_sel)) begin
        errors++;
        $display("[TB] FAIL %s voice got=%0d exp=%0d", tag, got_sel, exp_sel);
      end
      checks++;
      if (got_div !== (on ? div : 16'h0000)) begin
        errors++;
        $display("[TB] FAIL %s divider got=%h exp=%h", tag, got_div, on ? div : 16'h0000);
      end
    end
    checks++;
    if (n_steal != (exp_steal ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s steal_count got=%0d exp=%0d", tag, n_steal, exp_steal ? 1 : 0);
    end
    checks++;
    if (n_low != NV + 1) begin
      errors++;
      $display("[TB] FAIL %s ready_low_cycles got=%0d exp=%0d", tag, n_low, NV + 1);
    end
    checks++;
    if (voice_active !== exp_act) begin
      errors++;
      $display("[TB] FAIL %s voice_active got=%b exp=%b", tag, voice_active, exp_act);
    end
    checks++;
    if (midi_chan_selected !== last_sel || midi_chan_divider !== last_div) begin
      errors++;
      $display("[TB] FAIL %s held_outputs got=%0d/%h exp=%0d/%h", tag,
               midi_chan_selected, midi_chan_divider, last_sel, last_div);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (note_ready !== 1'b0 || midi_chan_update !== 1'b0 || steal_event !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b%b%b exp=000", note_ready, midi_chan_update, steal_event);
    end
    checks++;
    if (midi_chan_selected !== 2'd0 || midi_chan_divider !== 16'h0 || voice_active !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%0d/%h/%b exp=0/0000/0000",
               midi_chan_selected, midi_chan_divider, voice_active);
    end
    @(posedge sys_clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge sys_clk);
    checks++;
    if (note_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got=%b exp=1", note_ready);
    end
  endtask

  task automatic test_fill();
    check_event("fill_60", 1'b1, 7'd60, 16'h1000);
    check_event("fill_62", 1'b1, 7'd62, 16'h1001);
    check_event("fill_64", 1'b1, 7'd64, 16'h1002);
    check_event("fill_65", 1'b1, 7'd65, 16'h1003);
  endtask

  task automatic test_steal();
    check_event("steal_67", 1'b1, 7'd67, 16'h2000);
  endtask

  task automatic test_release_realloc();
    check_event("off_62", 1'b0, 7'd62, 16'hBEEF);
    check_event("realloc_69", 1'b1, 7'd69, 16'h2100);
  endtask

  task automatic test_retrigger();
    check_event("retrig_64", 1'b1, 7'd64, 16'h3000);
    check_event("steal_71", 1'b1, 7'd71, 16'h3100);
  endtask

  task automatic test_nomatch_off();
    check_event("off_nomatch_50", 1'b0, 7'd50, 16'h5555);
  endtask

  task automatic test_div_zero();
    check_event("div_zero_80", 1'b1, 7'd80, 16'h0000);
  endtask

  task automatic test_reset_abort();
    int n_strobe;
    n_strobe = 0;
    @(negedge sys_clk);
    note_valid = 1'b1;
    note_on    = 1'b1;
    note_num   = 7'd72;
    note_div   = 16'h4444;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    if (midi_chan_update === 1'b1) n_strobe++;
    checks++;
    if (note_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_ready_search got=%b exp=0", note_ready);
    end
    @(posedge sys_clk);
    #1 rst = 1'b1;
    @(negedge sys_clk);
    if (midi_chan_update === 1'b1) n_strobe++;
    checks++;
    if (note_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_ready_reset got=%b exp=0", note_ready);
    end
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    note_valid = 1'b0;
    model_reset();
    @(negedge sys_clk);
    checks++;
    if (note_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_ready_after got=%b exp=1", note_ready);
    end
    checks++;
    if (voice_active !== 4'b0000 || midi_chan_selected !== 2'd0 || midi_chan_divider !== 16'h0) begin
      errors++;
      $display("[TB] FAIL abort_state got=%b/%0d/%h exp=0000/0/0000",
               voice_active, midi_chan_selected, midi_chan_divider);
    end
    repeat (NV + 2) begin
      @(negedge sys_clk);
      if (midi_chan_update === 1'b1) n_strobe++;
    end
    checks++;
    if (n_strobe != 0) begin
      errors++;
      $display("[TB] FAIL abort_strobe got=%0d exp=0", n_strobe);
    end
  endtask

  task automatic test_random();
    bit          on;
    logic [6:0]  num;
    logic [15:0] div;
    for (int n = 0; n < 30; n++) begin
      on  = ($urandom_range(0, 9) < 7);
      num = 7'(60 + $urandom_range(0, 7));
      div = 16'($urandom);
      check_event("random", on, num, div);
    end
  endtask

  task automatic test_back_to_back();
    int          exp_q[$];
    int          cyc, last, issued, seen, sel;
    bit          es, st;
    logic [6:0]  num;
    logic [15:0] div;
    cyc = 0; last = -1; issued = 0; seen = 0;
    while (seen < 6 && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
      if (midi_chan_update === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_unexpected_strobe got=%0d exp=none", midi_chan_selected);
        end else begin
          if (midi_chan_selected !== 2'(exp_q[0])) begin
            errors++;
            $display("[TB] FAIL b2b_voice got=%0d exp=%0d", midi_chan_selected, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != NV + 2) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got=%0d exp=%0d", cyc - last, NV + 2);
          end
        end
        last = cyc;
        seen++;
      end
      if (note_ready === 1'b1) begin
        if (issued < 6) begin
          num = 7'(40 + $urandom_range(0, 5));
          div = 16'($urandom);
          model_apply(1'b1, num, div, es, sel, st);
          exp_q.push_back(sel);
          note_valid = 1'b1;
          note_on    = 1'b1;
          note_num   = num;
          note_div   = div;
          issued++;
        end else begin
          note_valid = 1'b0;
        end
      end
    end
    note_valid = 1'b0;
    checks++;
    if (seen != 6) begin
      errors++;
      $display("[TB] FAIL b2b_strobes got=%0d exp=6", seen);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_steal();
    test_release_realloc();
    test_retrigger();
    test_nomatch_off();
    test_div_zero();
    test_reset_abort();
    test_fill();
    test_random();
    test_back_to_back();
    check_event("after_b2b", 1'b1, 7'd90, 16'h7777);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the MIDI decode path and the TDM NCO voice bank. It accepts decoded note-on/note-off events carrying a precomputed NCO divider, assigns each note to one of four voice slots, and issues the one-cycle channel/divider update that reprograms the NCO bank. It retriggers a note that is already sounding, otherwise uses a free voice, and otherwise steals the least-recently-allocated voice.

## Interface
Parameters:
- NUM_VOICES, 4: voice slots; must be a power of two.
- VOICE_W, 2: log2(NUM_VOICES).
- NOTE_W, 7: MIDI note number width.
- D_W, 16: NCO divider width.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- note_valid  in  1  event offered.
- note_on  in  1  1 = note-on, 0 = note-off. Upstream converts velocity-0 note-on into note-off.
- note_num  in  NOTE_W  MIDI note number.
- note_div  in  D_W  NCO divider for the note; ignored on note-off.
- note_ready  out  1  allocator can accept an event.
- midi_chan_selected  out  VOICE_W  voice being reprogrammed.
- midi_chan_divider  out  D_W  new divider; 0 = voice silenced.
- midi_chan_update  out  1  one-cycle strobe; selected/divider valid in the same cycle.
- voice_active  out  NUM_VOICES  per-voice sounding flag.
- steal_event  out  1  one-cycle pulse coincident with a strobe that stole a sounding voice.

## Operation
- Per-voice state: active bit, note number (NOTE_W), age (VOICE_W).
- Invariant: the ages of the k active voices are exactly a permutation of 0..k-1. Age 0 is the newest voice. Age k-1 is the oldest.
- FSM states: IDLE, SEARCH, ISSUE.
  - IDLE: note_ready=1. On note_valid & note_ready, latch note_on, note_num and note_div, then go to SEARCH.
  - SEARCH: scan one voice per cycle, index 0..NUM_VOICES-1, for NUM_VOICES cycles. Record three things:
    - match: an active voice whose note equals note_num.
    - lowest-index free voice.
    - voice with age k-1.
  - ISSUE: apply the decision, then return to IDLE.
- Note-on decision priority:
  - Match found: retrigger voice v with the new divider. Active voices with age < age[v] increment; age[v] becomes 0.
  - Otherwise a free voice exists: take the lowest-index free voice v. All active voices increment; v becomes active with age 0.
  - Otherwise steal voice v with age NUM_VOICES-1. All other voices increment; age[v] becomes 0; assert steal_event.
  - Always store note_num, set midi_chan_divider=note_div, and assert midi_chan_update.
- Note-off:
  - Match on v: clear active[v]. Active voices with age > age[v] decrement; set age[v]=NUM_VOICES-1. Output divider 0 and strobe on v.
  - No match: no strobe and no state change. ISSUE is still traversed.
- note_div=0 on a note-on is forwarded unchanged, and the voice is marked active.
- midi_chan_selected and midi_chan_divider hold their last value between strobes.

## Timing
- Accept cycle A: the cycle with note_valid & note_ready. SEARCH runs A+1..A+NUM_VOICES. ISSUE is A+NUM_VOICES+1, with the strobe in that cycle (A+5 for 4 voices). note_ready returns high at A+NUM_VOICES+2.
- voice_active and ages update on the clock edge ending ISSUE, so they are visible at A+NUM_VOICES+2.
- note_ready is 0 outside IDLE. note_valid is ignored when ready is low, so the upstream must hold the event.
- Reset values:
  - FSM IDLE; all voices inactive; ages = NUM_VOICES-1; notes 0.
  - midi_chan_selected=0, midi_chan_divider=0, midi_chan_update=0, steal_event=0, voice_active=0.
  - note_ready=0 during the reset cycle and 1 from the first cycle after rst deasserts.
- rst during SEARCH or ISSUE aborts the event: no strobe is issued and no partial state is kept.
- Back-to-back events: throughput is one event per NUM_VOICES+2 cycles.

## Structure
- Package synth_pkg holds:
  - NUM_VOICES, VOICE_W, NOTE_W, D_W.
  - The FSM state enum {IDLE, SEARCH, ISSUE}.
  - The voice-slot record type {active, note, age}.
- One sub-module, voice_slot_table: per-voice registers, indexed read port for the scan, and an ISSUE-cycle age-update command (retrigger / alloc / steal / release, plus index).
- The FSM, match/free/oldest trackers and output registers live in voice_allocator.

## Test plan
- Reset, then note-ons 60, 62, 64, 65 (div 0x1000..0x1003) → strobes on voices 0, 1, 2, 3 at A+5 each; voice_active=4'b1111; ages v0..v3 = 3, 2, 1, 0.
- Then note-on 67 div 0x2000 → voice 0 strobe with div 0x2000 and steal_event=1; ages v0..v3 = 0, 3, 2, 1.
- Then note-off 62 → voice 1 strobe with div 0; voice_active=4'b1101. Then note-on 69 → voice 1 with no steal; ages v0..v3 = 1, 0, 3, 2.
- Then note-on 64 div 0x3000 (already held) → retrigger on voice 2; ages v0..v3 = 2, 1, 0, 3. A following note-on 71 steals voice 3.
- Note-off 50 with no match → no strobe and no state change; note_ready low for exactly 5 cycles after the accept cycle.
- Assert rst at A+2 of a note-on → no strobe; voice_active=0; note_ready=1 the cycle after rst deasserts. note_valid held high across that window is not accepted while ready is low.
